s27_frame_engine: RTL and testbench

Sequential, parametrised successor to the fixed time-frame-unrolled s27 netlists. It accepts a job of FRAMES input vectors for each of LANES independent s27 instances and steps the s27 next-state/output logic one frame per clock. It returns the per-frame G17 trace and the final flip-flop state over a valid/ready handshake. Its optional retained-state mode lets consecutive jobs continue one long simulation, which fixed unrolled netlists cannot do. It sits beside the unrolled netlists as the reference engine for sequential equivalence checks.

---
 rtl/s27_pkg.sv | 36 +++
 rtl/s27_frame_core.sv | 12 +
 rtl/s27_frame_engine.sv | 126 ++++++++++++
 tb/tb_s27_frame_engine.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/s27_pkg.sv
// Shared types, bit positions and the single-frame s27 next-state/output function.
package s27_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_state_t;

    localparam int unsigned G0_BIT = 0;
    localparam int unsigned G1_BIT = 1;
    localparam int unsigned G2_BIT = 2;
    localparam int unsigned G3_BIT = 3;

    localparam int unsigned G5_BIT = 0;
    localparam int unsigned G6_BIT = 1;
    localparam int unsigned G7_BIT = 2;

    // Returns {g17, next_state[2:0]} for one frame of one s27 instance.
    function automatic logic [3:0] s27_step(input logic [3:0] inputs, input logic [2:0] state);
        logic       a;
        logic       b;
        logic       n10;
        logic       g17;
        logic [2:0] nxt;
        a   = ~inputs[G1_BIT] & inputs[G3_BIT] & ~state[G7_BIT];
        b   = state[G6_BIT] & ~inputs[G0_BIT];
        n10 = ~a & ~b;
        g17 = state[G5_BIT] | n10;
        nxt[G5_BIT] = inputs[G0_BIT] & (state[G5_BIT] | ~a);
        nxt[G6_BIT] = ~g17;
        nxt[G7_BIT] = ~inputs[G2_BIT] & (inputs[G1_BIT] | state[G7_BIT]);
        return {g17, nxt};
    endfunction

endpackage

// File: rtl/s27_frame_core.sv
// Combinational evaluator for one frame of one s27 lane.
module s27_frame_core (
    input  logic [3:0] frame_in,
    input  logic [2:0] state_in,
    output logic       g17,
    output logic [2:0] state_next
);
    import s27_pkg::*;

    assign {g17, state_next} = s27_step(frame_in, state_in);

endmodule

// File: rtl/s27_frame_engine.sv
// Steps LANES s27 instances through a FRAMES-long job, one frame per clock,
// returning the G17 trace and final state over valid/ready.
module s27_frame_engine #(
    parameter int unsigned FRAMES = 4,
    parameter int unsigned LANES  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES*FRAMES*4-1:0]  in_frames,
    input  logic [LANES*3-1:0]         in_state,
    input  logic                       in_keep,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*FRAMES-1:0]    out_g17,
    output logic [LANES*3-1:0]         out_state
);
    import s27_pkg::*;

    localparam int unsigned KW = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int unsigned FW = LANES * FRAMES * 4;
    localparam int unsigned SW = LANES * 3;
    localparam int unsigned GW = LANES * FRAMES;

    fsm_state_t     state_q;
    fsm_state_t     state_d;
    logic [FW-1:0]  frames_q;
    logic [SW-1:0]  work_q;
    logic [SW-1:0]  work_next;
    logic [SW-1:0]  retained_q;
    logic [GW-1:0]  g17_q;
    logic [KW-1:0]  k_q;
    logic [LANES-1:0] lane_g17;
    logic           last_frame;

    // With FRAMES=1 the counter never leaves 0, so this is constantly true.
    assign last_frame = (k_q == KW'(FRAMES - 1));

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [FRAMES*4-1:0] lane_frames;
        logic [3:0]          lane_in;

        assign lane_frames = frames_q[l*FRAMES*4 +: FRAMES*4];

        always_comb begin
            lane_in = '0;
            for (int f = 0; f < FRAMES; f++) begin
                if (k_q == KW'(f)) lane_in = lane_frames[f*4 +: 4];
            end
        end

        s27_frame_core u_core (
            .frame_in   (lane_in),
            .state_in   (work_q[l*3 +: 3]),
            .g17        (lane_g17[l]),
            .state_next (work_next[l*3 +: 3])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)   state_d = RUN;
            RUN:     if (last_frame) state_d = DONE;
            DONE:    if (out_ready)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Job datapath: latch on accept, step per RUN cycle, freeze in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frames_q   <= '0;
            work_q     <= '0;
            retained_q <= '0;
            g17_q      <= '0;
            k_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        frames_q <= in_frames;
                        work_q   <= in_keep ? retained_q : in_state;
                        g17_q    <= '0;
                        k_q      <= '0;
                    end
                end
                RUN: begin
                    work_q <= work_next;
                    for (int l = 0; l < LANES; l++) begin
                        for (int f = 0; f < FRAMES; f++) begin
                            if (k_q == KW'(f)) g17_q[l*FRAMES + f] <= lane_g17[l];
                        end
                    end
                    if (last_frame) begin
                        retained_q <= work_next;
                        k_q        <= '0;
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_g17   = g17_q;
    assign out_state = retained_q;

endmodule

// File: tb/tb_s27_frame_engine.sv
// Directed bench for s27_frame_engine: a FRAMES=4/LANES=1 instance and a FRAMES=1/LANES=3 instance.
module tb_s27_frame_engine;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, in_keep, out_valid, out_ready;
    logic [15:0] in_frames;
    logic [2:0]  in_state, out_state;
    logic [3:0]  out_g17;

    logic        in_valid3, in_ready3, in_keep3, out_valid3, out_ready3;
    logic [11:0] in_frames3;
    logic [8:0]  in_state3, out_state3;
    logic [2:0]  out_g17_3;

    int n_checks = 0;
    int n_fail   = 0;

    s27_frame_engine #(.FRAMES(4), .LANES(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_frames(in_frames),
        .in_state(in_state), .in_keep(in_keep),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_g17(out_g17), .out_state(out_state)
    );

    s27_frame_engine #(.FRAMES(1), .LANES(3)) dut3 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_frames(in_frames3),
        .in_state(in_state3), .in_keep(in_keep3),
        .out_valid(out_valid3), .out_ready(out_ready3),
        .out_g17(out_g17_3), .out_state(out_state3)
    );

    // Independent reference written from the gate equations; returns {g17, G7, G6, G5}.
    function automatic logic [3:0] ref_step(input logic [3:0] x, input logic [2:0] s);
        logic a, b, g17, n5, n6, n7;
        a   = !(x[1] || !x[3] || s[2]);
        b   = s[1] && !x[0];
        g17 = s[0] || !(a || b);
        n5  = x[0] && (s[0] || !a);
        n6  = !g17;
        n7  = !(x[2] || !(x[1] || s[2]));
        return {g17, n7, n6, n5};
    endfunction

    // Runs one job on dut; called and returning at #1 after a rising edge.
    task automatic run_job(input logic [15:0] fr, input logic [2:0] st, input logic kp,
                           output logic [3:0] g, output logic [2:0] s, output int lat);
        int waitc;
        waitc = 0;
        while (!in_ready && waitc < 50) begin
            @(posedge clk); #1; waitc++;
        end
        if (!in_ready) begin
            n_checks++; n_fail++;
            $display("FAIL job_ready_timeout: in_ready=%b required 1", in_ready);
        end
        in_frames = fr; in_state = st; in_keep = kp; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        if (!out_valid) begin
            n_checks++; n_fail++;
            $display("FAIL job_done_timeout: out_valid=%b required 1", out_valid);
        end
        g = out_g17; s = out_state;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({in_ready, out_valid, out_g17, out_state} !== {1'b1, 1'b0, 4'b0000, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_outputs: ready=%b valid=%b g17=%b state=%b required 1 0 0000 000",
                     in_ready, out_valid, out_g17, out_state);
        end
        n_checks++;
        if ({in_ready3, out_valid3, out_g17_3, out_state3} !== {1'b1, 1'b0, 3'b000, 9'd0}) begin
            n_fail++;
            $display("FAIL reset_outputs3: ready=%b valid=%b g17=%b state=%b required 1 0 000 0",
                     in_ready3, out_valid3, out_g17_3, out_state3);
        end
    endtask

    task automatic test_basic();
        logic [3:0] g; logic [2:0] s; int lat;
        run_job(16'h0000, 3'b000, 1'b0, g, s, lat);
        n_checks++;
        if (g !== 4'b1111) begin n_fail++; $display("FAIL basic_g17: got %b required 1111", g); end
        n_checks++;
        if (s !== 3'b000) begin n_fail++; $display("FAIL basic_state: got %b required 000", s); end
        n_checks++;
        if (lat !== 4) begin n_fail++; $display("FAIL basic_latency: got %0d required 4", lat); end
    endtask

    task automatic test_keep();
        logic [3:0] g; logic [2:0] s; int lat;
        run_job(16'h0000, 3'b010, 1'b0, g, s, lat);
        n_checks++;
        if ({g, s} !== {4'b0000, 3'b010}) begin
            n_fail++; $display("FAIL keep_load: got g17=%b state=%b required 0000 010", g, s);
        end
        run_job(16'h0000, 3'b111, 1'b1, g, s, lat);
        n_checks++;
        if ({g, s} !== {4'b0000, 3'b010}) begin
            n_fail++; $display("FAIL keep_retained: got g17=%b state=%b required 0000 010", g, s);
        end
        run_job(16'h0000, 3'b000, 1'b0, g, s, lat);
        n_checks++;
        if ({g, s} !== {4'b1111, 3'b000}) begin
            n_fail++; $display("FAIL keep_off: got g17=%b state=%b required 1111 000", g, s);
        end
    endtask

    task automatic test_trace();
        logic [3:0] g; logic [2:0] s; int lat;
        run_job(16'h0010, 3'b010, 1'b0, g, s, lat);
        n_checks++;
        if (g !== 4'b1110) begin n_fail++; $display("FAIL trace_g17: got %b required 1110", g); end
        n_checks++;
        if (s !== 3'b000) begin n_fail++; $display("FAIL trace_state: got %b required 000", s); end
    endtask

    task automatic test_hold();
        int lat;
        logic [3:0] g; logic [2:0] s;
        in_frames = 16'h0000; in_state = 3'b010; in_keep = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        in_state = 3'b000;
        for (int i = 0; i < 10; i++) begin
            in_valid = ~in_valid;
            @(posedge clk); #1;
            n_checks++;
            if ({out_valid, in_ready, out_g17, out_state} !== {1'b1, 1'b0, 4'b0000, 3'b010}) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: valid=%b ready=%b g17=%b state=%b required 1 0 0000 010",
                         i, out_valid, in_ready, out_g17, out_state);
            end
        end
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++; $display("FAIL hold_release: ready=%b valid=%b required 1 0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL hold_next_accept: in_ready=%b required 0", in_ready);
        end
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        g = out_g17; s = out_state;
        n_checks++;
        if ({g, s} !== {4'b1111, 3'b000}) begin
            n_fail++; $display("FAIL hold_pending_job: got g17=%b state=%b required 1111 000", g, s);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [3:0] g; logic [2:0] s; int lat;
        run_job(16'h0000, 3'b010, 1'b0, g, s, lat);
        in_frames = 16'h0000; in_state = 3'b000; in_keep = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL midrun_busy: in_ready=%b required 0", in_ready);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({in_ready, out_valid, out_g17, out_state} !== {1'b1, 1'b0, 4'b0000, 3'b000}) begin
            n_fail++;
            $display("FAIL midrun_reset: ready=%b valid=%b g17=%b state=%b required 1 0 0000 000",
                     in_ready, out_valid, out_g17, out_state);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        run_job(16'h0000, 3'b111, 1'b1, g, s, lat);
        n_checks++;
        if ({g, s} !== {4'b1111, 3'b000}) begin
            n_fail++; $display("FAIL midrun_keep_after_reset: got g17=%b state=%b required 1111 000", g, s);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_ready, exp_valid;
        in_frames = 16'h0000; in_state = 3'b000; in_keep = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            exp_ready = (i % 6 == 5);
            exp_valid = (i % 6 == 4);
            n_checks++;
            if ({in_ready, out_valid} !== {exp_ready, exp_valid}) begin
                n_fail++;
                $display("FAIL b2b_edge%0d: ready=%b valid=%b required %b %b",
                         i, in_ready, out_valid, exp_ready, exp_valid);
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_lanes();
        logic [8:0]  ret;
        logic [8:0]  exp_s;
        logic [8:0]  start;
        logic [2:0]  exp_g;
        logic [3:0]  r;
        logic [11:0] fr;
        logic [8:0]  st;
        logic        kp;
        int          lat;
        ret = 9'd0;
        for (int j = 0; j < 8; j++) begin
            fr = 12'($urandom);
            st = 9'($urandom);
            kp = (j % 3 == 1);
            start = kp ? ret : st;
            for (int l = 0; l < 3; l++) begin
                r = ref_step(fr[l*4 +: 4], start[l*3 +: 3]);
                exp_g[l] = r[3];
                exp_s[l*3 +: 3] = r[2:0];
            end
            ret = exp_s;
            in_frames3 = fr; in_state3 = st; in_keep3 = kp; in_valid3 = 1'b1;
            @(posedge clk); #1;
            in_valid3 = 1'b0;
            lat = 0;
            while (!out_valid3 && lat < 20) begin
                @(posedge clk); #1; lat++;
            end
            n_checks++;
            if (lat !== 1) begin
                n_fail++; $display("FAIL lanes_latency_job%0d: got %0d required 1", j, lat);
            end
            n_checks++;
            if ({out_g17_3, out_state3} !== {exp_g, exp_s}) begin
                n_fail++;
                $display("FAIL lanes_result_job%0d: g17=%b state=%b required %b %b",
                         j, out_g17_3, out_state3, exp_g, exp_s);
            end
            out_ready3 = 1'b1;
            @(posedge clk); #1;
            out_ready3 = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_keep = 1'b0; out_ready = 1'b0; in_frames = '0; in_state = '0;
        in_valid3 = 1'b0; in_keep3 = 1'b0; out_ready3 = 1'b0; in_frames3 = '0; in_state3 = '0;
        #1;
        test_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        test_basic();
        test_keep();
        test_trace();
        test_hold();
        test_reset_mid_run();
        test_back_to_back();
        test_lanes();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
